// File: rtl/register_file.sv
// Architectural register file x0-x31 with per-register rename tags.
// Reads merge local state, same-cycle commit bypass and ROB forwarding.
module register_file #(
   parameter int unsigned ROB_WIDTH = 4
) (
   input  logic                 clockIn,
   input  logic                 resetIn,
   input  logic                 readyIn,
   input  logic                 clear,
   input  logic                 regUpdateValid,
   input  logic [4:0]           regUpdateDest,
   input  logic [31:0]          regValue,
   input  logic [ROB_WIDTH-1:0] regUpdateRobId,
   output logic [ROB_WIDTH-1:0] rs1Dep,
   input  logic                 rs1Ready,
   input  logic [31:0]          rs1Value,
   output logic [ROB_WIDTH-1:0] rs2Dep,
   input  logic                 rs2Ready,
   input  logic [31:0]          rs2Value,
   input  logic [4:0]           rs1,
   input  logic [4:0]           rs2,
   output logic [31:0]          val1,
   output logic                 has1,
   output logic [ROB_WIDTH-1:0] tag1,
   output logic [31:0]          val2,
   output logic                 has2,
   output logic [ROB_WIDTH-1:0] tag2,
   input  logic                 renameValid,
   input  logic [4:0]           renameDest,
   input  logic [ROB_WIDTH-1:0] renameRobId
);

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned DATA_W   = 32;

   logic [DATA_W-1:0]    value_q [NUM_REGS];
   logic [DATA_W-1:0]    value_d [NUM_REGS];
   logic [NUM_REGS-1:0]  busy_q;
   logic [NUM_REGS-1:0]  busy_d;
   logic [ROB_WIDTH-1:0] tag_q   [NUM_REGS];
   logic [ROB_WIDTH-1:0] tag_d   [NUM_REGS];

   logic commit_en;
   logic rename_en;

   assign commit_en = regUpdateValid && (regUpdateDest != 5'd0);
   assign rename_en = renameValid && (renameDest != 5'd0) && !clear;

   // Next state: commit first, then rename overrides busy/tag, then clear wipes busy.
   always_comb begin
      value_d = value_q;
      busy_d  = busy_q;
      tag_d   = tag_q;
      if (commit_en) begin
         value_d[regUpdateDest] = regValue;
         if (tag_q[regUpdateDest] == regUpdateRobId) begin
            busy_d[regUpdateDest] = 1'b0;
         end
      end
      if (rename_en) begin
         busy_d[renameDest] = 1'b1;
         tag_d[renameDest]  = renameRobId;
      end
      if (clear) begin
         busy_d = '0;
      end
   end

   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         busy_q <= '0;
      end else if (readyIn) begin
         value_q <= value_d;
         busy_q  <= busy_d;
         tag_q   <= tag_d;
      end
   end

   // Read port 1
   always_comb begin
      has1   = 1'b1;
      val1   = '0;
      tag1   = tag_q[rs1];
      rs1Dep = tag_q[rs1];
      if (rs1 != 5'd0) begin
         if (!busy_q[rs1]) begin
            val1 = value_q[rs1];
         end else if (regUpdateValid && (regUpdateDest == rs1) &&
                      (regUpdateRobId == tag_q[rs1])) begin
            val1 = regValue;
         end else begin
            has1 = rs1Ready;
            val1 = rs1Value;
         end
      end
   end

   // Read port 2
   always_comb begin
      has2   = 1'b1;
      val2   = '0;
      tag2   = tag_q[rs2];
      rs2Dep = tag_q[rs2];
      if (rs2 != 5'd0) begin
         if (!busy_q[rs2]) begin
            val2 = value_q[rs2];
         end else if (regUpdateValid && (regUpdateDest == rs2) &&
                      (regUpdateRobId == tag_q[rs2])) begin
            val2 = regValue;
         end else begin
            has2 = rs2Ready;
            val2 = rs2Value;
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: expected read results are queued with
// each stimulus step and popped once the combinational outputs settle.
module tb_register_file;

   localparam int unsigned RW = 4;

   logic          clockIn = 1'b0;
   logic          resetIn;
   logic          readyIn;
   logic          clear;
   logic          regUpdateValid;
   logic [4:0]    regUpdateDest;
   logic [31:0]   regValue;
   logic [RW-1:0] regUpdateRobId;
   logic [RW-1:0] rs1Dep, rs2Dep;
   logic          rs1Ready, rs2Ready;
   logic [31:0]   rs1Value, rs2Value;
   logic [4:0]    rs1, rs2;
   logic [31:0]   val1, val2;
   logic          has1, has2;
   logic [RW-1:0] tag1, tag2;
   logic          renameValid;
   logic [4:0]    renameDest;
   logic [RW-1:0] renameRobId;

   register_file #(.ROB_WIDTH(RW)) dut (
      .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clear(clear),
      .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
      .regValue(regValue), .regUpdateRobId(regUpdateRobId),
      .rs1Dep(rs1Dep), .rs1Ready(rs1Ready), .rs1Value(rs1Value),
      .rs2Dep(rs2Dep), .rs2Ready(rs2Ready), .rs2Value(rs2Value),
      .rs1(rs1), .rs2(rs2),
      .val1(val1), .has1(has1), .tag1(tag1),
      .val2(val2), .has2(has2), .tag2(tag2),
      .renameValid(renameValid), .renameDest(renameDest), .renameRobId(renameRobId)
   );

   always #5 clockIn = ~clockIn;

   typedef struct {
      logic          has1;
      logic [31:0]   val1;
      logic [RW-1:0] tag1;
      logic          has2;
      logic [31:0]   val2;
      logic [RW-1:0] tag2;
   } exp_t;

   exp_t  exp_q [$];
   string name_q [$];
   int    checks = 0;
   int    errors = 0;

   task automatic cmp(input string nm, input logic [31:0] obs, input logic [31:0] ex);
      checks++;
      assert (obs === ex) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, ex);
      end
   endtask

   task automatic expect_rd(input string nm, input logic h1, input logic [31:0] v1,
                            input logic [RW-1:0] t1, input logic h2,
                            input logic [31:0] v2, input logic [RW-1:0] t2);
      exp_t e;
      e.has1 = h1; e.val1 = v1; e.tag1 = t1;
      e.has2 = h2; e.val2 = v2; e.tag2 = t2;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Let combinational outputs settle, then drain the scoreboard.
   task automatic drain();
      exp_t  e;
      string nm;
      #1;
      while (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         cmp({nm, ".has1"}, 32'(has1), 32'(e.has1));
         cmp({nm, ".val1"}, val1, e.val1);
         cmp({nm, ".tag1"}, 32'(tag1), 32'(e.tag1));
         cmp({nm, ".rs1Dep"}, 32'(rs1Dep), 32'(e.tag1));
         cmp({nm, ".has2"}, 32'(has2), 32'(e.has2));
         cmp({nm, ".val2"}, val2, e.val2);
         cmp({nm, ".tag2"}, 32'(tag2), 32'(e.tag2));
         cmp({nm, ".rs2Dep"}, 32'(rs2Dep), 32'(e.tag2));
      end
   endtask

   task automatic tick();
      @(posedge clockIn);
      #1;
      renameValid    = 1'b0;
      regUpdateValid = 1'b0;
      clear          = 1'b0;
   endtask

   task automatic rename(input logic [4:0] d, input logic [RW-1:0] id);
      renameValid = 1'b1; renameDest = d; renameRobId = id;
   endtask

   task automatic commit(input logic [4:0] d, input logic [RW-1:0] id, input logic [31:0] v);
      regUpdateValid = 1'b1; regUpdateDest = d; regUpdateRobId = id; regValue = v;
   endtask

   initial begin
      resetIn = 1'b0; readyIn = 1'b1; clear = 1'b0;
      regUpdateValid = 1'b0; regUpdateDest = '0; regValue = '0; regUpdateRobId = '0;
      rs1Ready = 1'b0; rs1Value = '0; rs2Ready = 1'b0; rs2Value = '0;
      rs1 = 5'd5; rs2 = 5'd0;
      renameValid = 1'b0; renameDest = '0; renameRobId = '0;

      expect_rd("reset", 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
      drain();
      #8 resetIn = 1'b1;
      tick();

      // Rename x3 -> 7, then read it pending and via ROB forwarding
      rename(5'd3, 4'd7);
      tick();
      rs1 = 5'd3; rs2 = 5'd3;
      rs2Ready = 1'b1; rs2Value = 32'hBEEF;
      expect_rd("x3_pending", 1'b0, 32'h0, 4'd7, 1'b1, 32'hBEEF, 4'd7);
      drain();
      rs1Ready = 1'b1; rs1Value = 32'hABCD;
      rs2Ready = 1'b0; rs2Value = 32'h0;
      expect_rd("x3_rob_fwd", 1'b1, 32'hABCD, 4'd7, 1'b0, 32'h0, 4'd7);
      drain();

      // Commit bypass in the same cycle, then array value next cycle
      rs1Ready = 1'b0; rs1Value = 32'h0; rs2 = 5'd0;
      commit(5'd3, 4'd7, 32'h1234);
      expect_rd("x3_bypass", 1'b1, 32'h1234, 4'd7, 1'b1, 32'h0, 4'd0);
      drain();
      tick();
      expect_rd("x3_committed", 1'b1, 32'h1234, 4'd7, 1'b1, 32'h0, 4'd0);
      drain();

      // Stale commit must not clear a newer rename
      rename(5'd4, 4'd2); tick();
      rename(5'd4, 4'd5); tick();
      rs1 = 5'd4;
      commit(5'd4, 4'd2, 32'h11);
      expect_rd("x4_stale_commit", 1'b0, 32'h0, 4'd5, 1'b1, 32'h0, 4'd0);
      drain();
      tick();
      expect_rd("x4_still_busy", 1'b0, 32'h0, 4'd5, 1'b1, 32'h0, 4'd0);
      drain();
      commit(5'd4, 4'd5, 32'h22);
      expect_rd("x4_bypass", 1'b1, 32'h22, 4'd5, 1'b1, 32'h0, 4'd0);
      drain();
      tick();
      expect_rd("x4_done", 1'b1, 32'h22, 4'd5, 1'b1, 32'h0, 4'd0);
      drain();

      // Same-cycle commit and rename on x6: rename wins busy/tag
      rename(5'd6, 4'd1); tick();
      commit(5'd6, 4'd1, 32'h66);
      rename(5'd6, 4'd9);
      tick();
      rs1 = 5'd6;
      expect_rd("x6_rename_wins", 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'd0);
      drain();

      // x0 ignores rename and commit
      rs1 = 5'd0; rs2 = 5'd0;
      rename(5'd0, 4'd3);
      commit(5'd0, 4'd0, 32'h55);
      tick();
      expect_rd("x0_const", 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
      drain();

      // Clear drops busy bits and a same-cycle rename
      rename(5'd8, 4'd10); tick();
      rename(5'd9, 4'd11); tick();
      clear = 1'b1;
      rename(5'd10, 4'd12);
      tick();
      rs1 = 5'd8; rs2 = 5'd9;
      expect_rd("clear_x8_x9", 1'b1, 32'h0, 4'd10, 1'b1, 32'h0, 4'd11);
      drain();
      rs1 = 5'd10; rs2 = 5'd6;
      expect_rd("clear_x10_x6", 1'b1, 32'h0, 4'd0, 1'b1, 32'h66, 4'd9);
      drain();

      // readyIn low holds all state
      readyIn = 1'b0;
      rename(5'd11, 4'd13);
      commit(5'd12, 4'd0, 32'hAA);
      tick();
      readyIn = 1'b1;
      rs1 = 5'd11; rs2 = 5'd12;
      expect_rd("hold_x11_x12", 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
      drain();

      // Async reset mid-cycle wipes everything
      rs1 = 5'd3; rs2 = 5'd4;
      expect_rd("pre_reset", 1'b1, 32'h1234, 4'd7, 1'b1, 32'h22, 4'd5);
      drain();
      #1 resetIn = 1'b0;
      expect_rd("async_reset", 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
      drain();
      resetIn = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file with per-register rename tags. It sits between the instruction unit and the reorder buffer. It holds x0–x31, and records for each register whether a ROB entry will produce it and which entry that is. It serves operand reads to the instruction unit by combining its own values with the ROB's forwarded values. It consumes the ROB's in-order commit stream and its branch-mispredict clear.

## Interface
- ROB_WIDTH, 4, width of ROB index; the tag width.
- clockIn  in  1  single clock; all state updates on its rising edge.
- resetIn  in  1  asynchronous, active-low reset.
- readyIn  in  1  global enable; state updates only when high.
- clear  in  1  ROB mispredict flush.
- regUpdateValid  in  1  ROB commit strobe.
- regUpdateDest  in  5  committed destination register.
- regValue  in  32  committed value.
- regUpdateRobId  in  ROB_WIDTH  ROB index of the committing entry.
- rs1Dep  out  ROB_WIDTH  tag of rs1's pending producer; goes to the ROB.
- rs1Ready  in  1  ROB reports the rs1Dep entry as ready.
- rs1Value  in  32  ROB value for rs1Dep.
- rs2Dep, rs2Ready, rs2Value: same as the three rs1 ports, for rs2.
- rs1  in  5  instruction unit source register 1.
- rs2  in  5  instruction unit source register 2.
- val1  out  32  rs1 operand value; meaningful only when has1 is high.
- has1  out  1  rs1 operand value is available.
- tag1  out  ROB_WIDTH  ROB tag to wait on when has1 is low.
- val2, has2, tag2: same as the three rs1 outputs, for rs2.
- renameValid  in  1  instruction unit allocates a ROB entry that writes a register.
- renameDest  in  5  destination of the renamed instruction.
- renameRobId  in  ROB_WIDTH  ROB index allocated to it.

## Operation
- State per register r: value[r] (32 bits), busy[r], tag[r] (ROB_WIDTH bits).
- x0 always reads value 0 with has 1. Writes and renames targeting x0 are ignored.
- Read path is combinational. It is evaluated for each port independently (shown for port 1, r = rs1):
  - r == 0 → val1 = 0, has1 = 1.
  - !busy[r] → val1 = value[r], has1 = 1.
  - busy[r], regUpdateValid, regUpdateDest == r and regUpdateRobId == tag[r] → val1 = regValue, has1 = 1. This is the same-cycle commit bypass.
  - Otherwise → has1 = rs1Ready, val1 = rs1Value. The ROB's own forwarding covers results completing this cycle.
  - tag1 = tag[r] always. rs1Dep = tag[r] always.
- Reads see the state as it was before this cycle's rename. An instruction whose source equals its own destination therefore gets the previous producer or value.
- Commit, on a rising edge with readyIn high and regUpdateValid high and regUpdateDest != 0:
  - value[dest] is set to regValue.
  - busy[dest] is cleared only if tag[dest] == regUpdateRobId and no same-cycle rename targets dest.
- Rename, on a rising edge with readyIn high, renameValid high, renameDest != 0 and clear low: busy[dest] is set to 1 and tag[dest] to renameRobId. When rename and commit hit the same register in the same cycle, the rename's busy and tag win and the commit's value write still happens.
- Clear, on a rising edge with readyIn high and clear high:
  - All busy bits are cleared.
  - A rename in the same cycle is dropped.
  - A commit in the same cycle still writes its value, because committed work is architectural.
- readyIn low: all state holds. Read outputs remain live.

## Timing
- resetIn low, at any time and independent of the clock: all value, busy and tag entries go to 0.
- After reset, every has output is 1, every val output is 0, every tag and Dep output is 0.
- Read latency is 0 cycles, purely combinational from rs1/rs2, the commit inputs, and the ROB ready/value inputs.
- Commit or rename becomes visible to reads one cycle after the edge, except through the commit bypass described above.
- A reset asserted mid-operation discards all state immediately. The first edge after reset is released behaves as from the reset state.
- There are no backpressure outputs. The block accepts one commit and one rename per cycle unconditionally.

## Test plan
- Reset, then read rs1 = 5 and rs2 = 0 → has1 = has2 = 1, val1 = val2 = 0.
- Rename x3 to tag 7. Next cycle read rs1 = 3 with rs1Ready = 0 → has1 = 0, tag1 = 7, rs1Dep = 7. Then drive rs1Ready = 1 and rs1Value = 0xABCD → has1 = 1, val1 = 0xABCD.
- x3 busy with tag 7. Commit dest 3, robId 7, value 0x1234 while reading rs1 = 3 → same cycle has1 = 1, val1 = 0x1234. Next cycle busy cleared and val1 = 0x1234 from the array.
- Rename x4 to tag 2, then to tag 5. Commit dest 4, robId 2, value 0x11 → x4 stays busy with tag 5, value[4] = 0x11. Commit robId 5, value 0x22 → not busy, value 0x22.
- Same cycle: commit dest 6 with matching tag and rename x6 to tag 9 → x6 busy with tag 9, value[6] updated. Rename and commit to x0 → x0 still reads 0, has 1.
- Rename x8 and x9, then assert clear together with a rename of x10 → all three not busy. readyIn = 0 with a rename of x11 → x11 is unchanged. Assert resetIn low asynchronously → all values read 0.
